regfile_param: RTL and testbench

Parametrised multi-port register file, successor to the fixed 32x32 single-write RegisterFile. Adds configurable data width and depth, a second write port with defined collision priority, a hardwired zero register option, write-to-read bypass, and a selectable registered-read mode. It is the datapath register store between decode (read addresses) and writeback (write ports).

---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 78 +++++++
 tb/tb_regfile_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Bus between decode/writeback and the register file: two read ports and two write ports.
// The write-collision flag travels with the read data.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Read1;
  logic [ADDR_W-1:0] Read2;
  logic [ADDR_W-1:0] WriteReg;
  logic              RegWrite;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] WriteReg2;
  logic              RegWrite2;
  logic [DATA_W-1:0] WriteData2;
  logic [DATA_W-1:0] Data1;
  logic [DATA_W-1:0] Data2;
  logic              WrCollide;

  modport master (
    output Read1, Read2, WriteReg, RegWrite, WriteData,
    output WriteReg2, RegWrite2, WriteData2,
    input  Data1, Data2, WrCollide
  );

  modport slave (
    input  Read1, Read2, WriteReg, RegWrite, WriteData,
    input  WriteReg2, RegWrite2, WriteData2,
    output Data1, Data2, WrCollide
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/2-write register file. Port B wins same-address collisions, and r0 can be
// hardwired to zero. Reads are either combinational (with optional write bypass) or registered.
module regfile_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int RD_REG  = 0,
  parameter int BYPASS  = 1
) (
  input logic            clk,
  input logic            rst,
  regfile_param_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [NREGS];
  logic              collide_reg;
  logic              collide_next;
  logic              wr_a_ok;
  logic              wr_b_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  // Writes to r0 are dropped entirely when it is hardwired, so they can never collide.
  assign wr_a_ok      = bus.RegWrite  && !(ZERO_R0 != 0 && bus.WriteReg  == '0);
  assign wr_b_ok      = bus.RegWrite2 && !(ZERO_R0 != 0 && bus.WriteReg2 == '0);
  assign collide_next = wr_a_ok && wr_b_ok && (bus.WriteReg == bus.WriteReg2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_reg[i] <= '0;
      collide_reg <= 1'b0;
    end else begin
      if (wr_a_ok) mem_reg[bus.WriteReg] <= bus.WriteData;
      // Later assignment wins, giving port B priority on a shared address.
      if (wr_b_ok) mem_reg[bus.WriteReg2] <= bus.WriteData2;
      collide_reg <= collide_next;
    end
  end

  assign raddr[0] = bus.Read1;
  assign raddr[1] = bus.Read2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] stored_val;
      logic [DATA_W-1:0] post_wr_val;

      // post_wr_val is what the addressed register holds once this edge's writes land.
      always_comb begin
        stored_val  = mem_reg[raddr[gi]];
        post_wr_val = stored_val;
        if (wr_a_ok && bus.WriteReg  == raddr[gi]) post_wr_val = bus.WriteData;
        if (wr_b_ok && bus.WriteReg2 == raddr[gi]) post_wr_val = bus.WriteData2;
        if (ZERO_R0 != 0 && raddr[gi] == '0) begin
          stored_val  = '0;
          post_wr_val = '0;
        end
      end

      if (RD_REG != 0) begin : g_reg
        logic [DATA_W-1:0] data_reg;
        always_ff @(posedge clk) begin
          if (rst) data_reg <= '0;
          else     data_reg <= post_wr_val;
        end
        assign rdata[gi] = data_reg;
      end else begin : g_comb
        assign rdata[gi] = (BYPASS != 0) ? post_wr_val : stored_val;
      end
    end
  endgenerate

  assign bus.Data1     = rdata[0];
  assign bus.Data2     = rdata[1];
  assign bus.WrCollide = collide_reg;
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: four parameter configurations driven in lockstep,
// directed vector table, randomized traffic against an array model, reset and depth sweeps.
`timescale 1ns/1ps
module tb_regfile_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        we, we2;
  logic [4:0]  wa, wa2, r1, r2;
  logic [31:0] wd, wd2;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // cfg0: defaults; cfg1: ordinary r0, no bypass; cfg2: registered reads; cfg3: 16x8
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
  regfile_param_if #(.DATA_W(16), .ADDR_W(3)) if3 ();

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .RD_REG(0), .BYPASS(1))
    u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .RD_REG(0), .BYPASS(0))
    u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .RD_REG(1), .BYPASS(1))
    u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1), .RD_REG(0), .BYPASS(1))
    u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  assign if0.Read1 = r1;  assign if0.Read2 = r2;  assign if0.WriteReg = wa;  assign if0.WriteReg2 = wa2;
  assign if0.RegWrite = we;  assign if0.RegWrite2 = we2;  assign if0.WriteData = wd;  assign if0.WriteData2 = wd2;
  assign if1.Read1 = r1;  assign if1.Read2 = r2;  assign if1.WriteReg = wa;  assign if1.WriteReg2 = wa2;
  assign if1.RegWrite = we;  assign if1.RegWrite2 = we2;  assign if1.WriteData = wd;  assign if1.WriteData2 = wd2;
  assign if2.Read1 = r1;  assign if2.Read2 = r2;  assign if2.WriteReg = wa;  assign if2.WriteReg2 = wa2;
  assign if2.RegWrite = we;  assign if2.RegWrite2 = we2;  assign if2.WriteData = wd;  assign if2.WriteData2 = wd2;
  assign if3.Read1 = r1[2:0];  assign if3.Read2 = r2[2:0];  assign if3.WriteReg = wa[2:0];  assign if3.WriteReg2 = wa2[2:0];
  assign if3.RegWrite = we;  assign if3.RegWrite2 = we2;  assign if3.WriteData = wd[15:0];  assign if3.WriteData2 = wd2[15:0];

  logic [31:0] d1_act [4];
  logic [31:0] d2_act [4];
  logic        col_act [4];
  assign d1_act[0] = if0.Data1;  assign d2_act[0] = if0.Data2;  assign col_act[0] = if0.WrCollide;
  assign d1_act[1] = if1.Data1;  assign d2_act[1] = if1.Data2;  assign col_act[1] = if1.WrCollide;
  assign d1_act[2] = if2.Data1;  assign d2_act[2] = if2.Data2;  assign col_act[2] = if2.WrCollide;
  assign d1_act[3] = {16'h0, if3.Data1};  assign d2_act[3] = {16'h0, if3.Data2};  assign col_act[3] = if3.WrCollide;

  // Per-configuration rules for the model.
  localparam bit          ZR [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit          BY [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam bit          RR [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [4:0]  AM [4] = '{5'd31, 5'd31, 5'd31, 5'd7};
  localparam logic [31:0] DM [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

  logic [31:0] model [4][32];
  logic [31:0] exp_r1 [4];
  logic [31:0] exp_r2 [4];
  logic        exp_col [4];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Register contents after the coming edge: stored value overwritten by A, then by B.
  function automatic logic [31:0] post_val(int c, logic [4:0] a);
    logic [4:0]  am;
    logic [31:0] v;
    am = a & AM[c];
    if (ZR[c] && am == 5'd0) return 32'h0;
    v = model[c][am];
    if (we  && (wa  & AM[c]) == am) v = wd  & DM[c];
    if (we2 && (wa2 & AM[c]) == am) v = wd2 & DM[c];
    return v;
  endfunction

  function automatic logic [31:0] comb_exp(int c, logic [4:0] a);
    logic [4:0] am;
    am = a & AM[c];
    if (ZR[c] && am == 5'd0) return 32'h0;
    return BY[c] ? post_val(c, a) : model[c][am];
  endfunction

  task automatic model_pre();
    for (int c = 0; c < 4; c++) begin
      if (RR[c]) begin
        chk($sformatf("hold_d1_c%0d", c), d1_act[c], exp_r1[c]);
        chk($sformatf("hold_d2_c%0d", c), d2_act[c], exp_r2[c]);
      end else if (!rst) begin
        chk($sformatf("comb_d1_c%0d_a%0d", c, r1), d1_act[c], comb_exp(c, r1));
        chk($sformatf("comb_d2_c%0d_a%0d", c, r2), d2_act[c], comb_exp(c, r2));
      end
    end
  endtask

  task automatic commit();
    logic [4:0] a, b;
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) model[c][i] = 32'h0;
        exp_r1[c] = 32'h0;  exp_r2[c] = 32'h0;  exp_col[c] = 1'b0;
      end else begin
        a = wa & AM[c];
        b = wa2 & AM[c];
        exp_r1[c]  = post_val(c, r1);
        exp_r2[c]  = post_val(c, r2);
        exp_col[c] = we && we2 && (a == b) && !(ZR[c] && a == 5'd0);
        if (we  && !(ZR[c] && a == 5'd0)) model[c][a] = wd  & DM[c];
        if (we2 && !(ZR[c] && b == 5'd0)) model[c][b] = wd2 & DM[c];
      end
    end
  endtask

  task automatic model_post();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("collide_c%0d", c), {31'h0, col_act[c]}, {31'h0, exp_col[c]});
      if (RR[c]) begin
        chk($sformatf("reg_d1_c%0d", c), d1_act[c], exp_r1[c]);
        chk($sformatf("reg_d2_c%0d", c), d2_act[c], exp_r2[c]);
      end
    end
  endtask

  task automatic cycle(bit do_chk);
    @(negedge clk);
    if (do_chk) model_pre();
    @(posedge clk);
    commit();
    #1;
    if (do_chk) model_post();
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; we2 = 1'b0; wa = 5'd0; wa2 = 5'd0; wd = 32'h0; wd2 = 32'h0;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we2;
    logic [4:0]  wa2;
    logic [31:0] wd2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e_d1;   // cfg0 Data1 before the edge
    logic        e_col;  // cfg0 WrCollide after the edge
    logic [31:0] e_d2r;  // cfg2 Data2 after the edge
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 5'd1, 32'h12345678, 1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'h12345678, 1'b0, 32'h12345678};
    tbl[1]  = '{1'b1, 1'b1, 5'd1, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'h0,        1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 5'd1, 32'h55555555, 1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'h55555555, 1'b0, 32'h55555555};
    tbl[4]  = '{1'b0, 1'b1, 5'd1, 32'hAAAAAAAA, 1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd1, 5'd1, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA};
    tbl[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 32'h22222222, 1'b1, 32'h22222222};
    tbl[9]  = '{1'b0, 1'b1, 5'd7, 32'h33333333, 1'b1, 5'd7, 32'h44444444, 5'd7, 5'd7, 32'h44444444, 1'b1, 32'h44444444};
    tbl[10] = '{1'b0, 1'b1, 5'd7, 32'h77777777, 1'b1, 5'd8, 32'h88888888, 5'd8, 5'd7, 32'h88888888, 1'b0, 32'h77777777};
    tbl[11] = '{1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 32'hDEADBEEF, 1'b0, 32'h0};

    idle();
    r1 = 5'd0; r2 = 5'd0;
    rst = 1'b1;
    cycle(1'b0);

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      we2 = tbl[i].we2; wa2 = tbl[i].wa2; wd2 = tbl[i].wd2; r1 = tbl[i].r1; r2 = tbl[i].r2;
      @(negedge clk);
      if (!tbl[i].rst) chk($sformatf("tbl%0d_d1", i), d1_act[0], tbl[i].e_d1);
      model_pre();
      @(posedge clk);
      commit();
      #1;
      chk($sformatf("tbl%0d_col", i), {31'h0, col_act[0]}, {31'h0, tbl[i].e_col});
      chk($sformatf("tbl%0d_d2r", i), d2_act[2], tbl[i].e_d2r);
      model_post();
      $display("vec %0d rst=%0b wA=%0b@%0d=%h wB=%0b@%0d=%h r=%0d/%0d d1=%h col=%0b",
               i, rst, we, wa, wd, we2, wa2, wd2, r1, r2, d1_act[0], col_act[0]);
    end

    // Randomized traffic with biased collisions and read-of-write-target.
    for (int n = 0; n < 200; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom_range(0, 1));
      we2 = 1'($urandom_range(0, 1));
      wa  = 5'($urandom);
      wa2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      wd  = $urandom;
      wd2 = $urandom;
      r1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      r2  = ($urandom_range(0, 2) == 0) ? wa2 : 5'($urandom);
      cycle(1'b1);
      $display("rnd %0d rst=%0b wA=%0b@%0d wB=%0b@%0d r=%0d/%0d d1=%h d2=%h",
               n, rst, we, wa, we2, wa2, r1, r2, d1_act[0], d2_act[0]);
    end

    // Reset clears every register.
    idle();
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r1 = 5'(i);
      r2 = 5'(31 - i);
      cycle(1'b1);
      chk($sformatf("rst_sweep_r%0d", i), d1_act[1], 32'h0);
      $display("rst_sweep r%0d d1=%h", i, d1_act[1]);
    end

    // 16x8 configuration: r7, r0 ignored, then full depth.
    idle();
    we = 1'b1; wa = 5'd7; wd = 32'h1234BEEF;
    cycle(1'b1);
    idle();
    r1 = 5'd7;
    cycle(1'b1);
    chk("narrow_r7", d1_act[3], 32'h0000BEEF);
    $display("narrow r7 d1=%h", d1_act[3]);
    we = 1'b1; wa = 5'd0; wd = 32'h0000FFFF;
    cycle(1'b1);
    idle();
    r1 = 5'd0;
    cycle(1'b1);
    chk("narrow_r0", d1_act[3], 32'h0);
    $display("narrow r0 d1=%h", d1_act[3]);
    for (int i = 0; i < 8; i++) begin
      idle();
      we = 1'b1; wa = 5'(i); wd = 32'h5A5A_A000 + 32'(i) * 32'h111;
      cycle(1'b1);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      r1 = 5'(i);
      r2 = 5'(7 - i);
      cycle(1'b1);
      chk($sformatf("narrow_depth_r%0d", i), d1_act[3],
          (i == 0) ? 32'h0 : (32'h0000_A000 + 32'(i) * 32'h111));
      $display("narrow_depth r%0d d1=%h", i, d1_act[3]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
